// File: rtl/alu_mul_scheduler.sv
// alu_mul_scheduler
// -----------------
// Two-requester front end that shares one combinational ALU and one
// multi-cycle multiplier. It accepts one operation at a time, chosen
// round-robin between the requesters. An operation runs on the ALU when
// ctrl bit 2 is clear and on the multiplier when it is set. The result is
// held on the response port until the consumer takes it.
//
// Optional feature: define MUL_TIMEOUT_EN to abandon a multiply that runs
// longer than MULT_TIMEOUT cycles. The block then returns an error
// response with zero data.
//
// Ports
//   clk, resetn                   clock, asynchronous active-low reset
//   req_valid[1:0]/req_ready[1:0] per-requester request handshake
//   req_ctrl[27:0]                14-bit control word per requester (bit 2 = multiply)
//   req_src1/req_src2[63:0]       32-bit operands per requester
//   alu_control/alu_src1/alu_src2 operation sent to the external ALU
//   alu_result                    result returned by the external ALU
//   mult_begin/mult_op1/mult_op2  operation sent to the external multiplier
//   product, mult_end             result and done flag from the multiplier
//   rsp_valid/rsp_ready           response handshake
//   rsp_id/rsp_err/rsp_hi/rsp_lo  response payload
module alu_mul_scheduler #(
  parameter int MULT_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [27:0] req_ctrl,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  output logic [13:0] alu_control,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] alu_result,
  output logic        mult_begin,
  output logic [31:0] mult_op1,
  output logic [31:0] mult_op2,
  input  logic [63:0] product,
  input  logic        mult_end,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  input  logic        rsp_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALU_EXEC = 2'd1,
    MUL_WAIT = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic [1:0]  grant;
  logic        accept;
  logic        acc_id;
  logic [13:0] sel_ctrl;
  logic [31:0] sel_src1;
  logic [31:0] sel_src2;
  logic [13:0] op_ctrl;
  logic [31:0] op_src1;
  logic [31:0] op_src2;
  logic        op_id;
  logic        mul_timeout;

  // Round-robin pick. A tie goes to the requester that did not win last
  // time. last_grant resets to 1 so that requester 0 wins the first tie.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // A grant only becomes visible in IDLE. It is also masked while reset is
  // held, because the grant is combinational from req_valid.
  assign req_ready = (state == IDLE && resetn) ? grant : 2'b00;
  assign accept    = (state == IDLE) && (grant != 2'b00);
  assign acc_id    = grant[1];
  assign sel_ctrl  = acc_id ? req_ctrl[27:14] : req_ctrl[13:0];
  assign sel_src1  = acc_id ? req_src1[63:32] : req_src1[31:0];
  assign sel_src2  = acc_id ? req_src2[63:32] : req_src2[31:0];

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. The RESP -> IDLE step spends one full cycle in IDLE
  // before the next grant, so req_ready never coincides with the response
  // handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = sel_ctrl[2] ? MUL_WAIT : ALU_EXEC;
      ALU_EXEC: state_nxt = RESP;
      MUL_WAIT: if (mult_end || mul_timeout) state_nxt = RESP;
      RESP:     if (rsp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Latch the accepted operation so later req_* activity cannot disturb it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_ctrl    <= '0;
      op_src1    <= '0;
      op_src2    <= '0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      op_ctrl    <= sel_ctrl;
      op_src1    <= sel_src1;
      op_src2    <= sel_src2;
      op_id      <= acc_id;
      last_grant <= acc_id;
    end
  end

  // Result capture. A timed-out multiply still lands here, but with zero
  // data. mult_end seen outside MUL_WAIT never reaches these registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_hi <= '0;
      rsp_lo <= '0;
    end else if (state == ALU_EXEC) begin
      rsp_hi <= '0;
      rsp_lo <= alu_result;
    end else if (state == MUL_WAIT && (mult_end || mul_timeout)) begin
      rsp_hi <= mult_end ? product[63:32] : 32'd0;
      rsp_lo <= mult_end ? product[31:0]  : 32'd0;
    end
  end

`ifdef MUL_TIMEOUT_EN
  localparam int CNT_W = $clog2(MULT_TIMEOUT + 1);

  logic [CNT_W-1:0] mul_cnt;
  logic             err_q;

  // mult_end wins if it arrives in the same cycle the limit is reached
  assign mul_timeout = (state == MUL_WAIT) && !mult_end &&
                       (mul_cnt == CNT_W'(MULT_TIMEOUT - 1));

  // Counts the cycles spent in MUL_WAIT. It is cleared on acceptance so
  // that it starts from zero on entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_cnt <= '0;
    end else if (accept) begin
      mul_cnt <= '0;
    end else if (state == MUL_WAIT) begin
      mul_cnt <= mul_cnt + 1'b1;
    end
  end

  // Error flag for the response: set only by a timeout
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (state == ALU_EXEC) begin
      err_q <= 1'b0;
    end else if (state == MUL_WAIT && (mult_end || mul_timeout)) begin
      err_q <= mul_timeout;
    end
  end

  assign rsp_err = err_q;
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(MULT_TIMEOUT);
  assign mul_timeout    = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  assign alu_control = (state == IDLE) ? 14'd0 : op_ctrl;
  assign alu_src1    = op_src1;
  assign alu_src2    = op_src2;
  assign mult_op1    = op_src1;
  assign mult_op2    = op_src2;
  assign mult_begin  = (state == MUL_WAIT);
  assign rsp_valid   = (state == RESP);
  assign rsp_id      = op_id;

endmodule

// File: tb/tb_alu_mul_scheduler.sv
// tb_alu_mul_scheduler
// --------------------
// Directed bench for alu_mul_scheduler. It contains a small ALU model
// (add for ctrl 0x0001, subtract otherwise) and a multiplier model that
// raises mult_end in the 33rd cycle of mult_begin. Expected values are
// worked out by hand. The timeout scenario runs only when MUL_TIMEOUT_EN
// is defined, and the DUT is built with MULT_TIMEOUT = 8.
module tb_alu_mul_scheduler;

  localparam int MUL_LAT = 33;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [27:0] req_ctrl;
  logic [63:0] req_src1;
  logic [63:0] req_src2;
  logic [13:0] alu_control;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;
  logic        mult_begin;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic [63:0] product;
  logic        mult_end;
  logic        rsp_valid;
  logic        rsp_id;
  logic        rsp_err;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic        rsp_ready;

  logic        mul_on;
  logic        stray_end;
  int          mcnt;
  int          compared = 0;
  int          mismatched = 0;
  logic        saw_valid;
  logic        saw_begin;

  alu_mul_scheduler #(.MULT_TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
    .req_src1(req_src1), .req_src2(req_src2),
    .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result),
    .mult_begin(mult_begin), .mult_op1(mult_op1), .mult_op2(mult_op2),
    .product(product), .mult_end(mult_end),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  // ALU model
  assign alu_result = (alu_control == 14'h0001) ? alu_src1 + alu_src2
                                                : alu_src1 - alu_src2;

  // Multiplier model: counts the cycles mult_begin has been high
  always @(posedge clk or negedge resetn) begin
    if (!resetn)         mcnt <= 0;
    else if (mult_begin) mcnt <= mcnt + 1;
    else                 mcnt <= 0;
  end

  assign mult_end = (mul_on && mult_begin && mcnt == MUL_LAT - 1) || stray_end;
  assign product  = {32'd0, mult_op1} * {32'd0, mult_op2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] v,
                               input logic [13:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [13:0] c1, input logic [31:0] a1, input logic [31:0] b1);
    req_valid = v;
    req_ctrl  = {c1, c0};
    req_src1  = {a1, a0};
    req_src2  = {b1, b0};
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    resetn    = 1'b0;
    rsp_ready = 1'b1;
    mul_on    = 1'b1;
    stray_end = 1'b0;
    applyStimulus(2'b11, 14'h1, 1, 1, 14'h1, 2, 2);

    // Reset state
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_mult_begin", mult_begin, 0);
    checkOutput("rst_alu_control", alu_control, 0);
    checkOutput("rst_rsp_data", {rsp_hi, rsp_lo}, 0);
    checkOutput("rst_rsp_id_err", {rsp_id, rsp_err}, 0);
    checkOutput("rst_alu_src1", alu_src1, 0);
    tick();
    tick();
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    #1;

    // ALU operation from requester 0: 5 + 7
    applyStimulus(2'b01, 14'h0001, 5, 7, 0, 0, 0);
    checkOutput("alu_grant", req_ready, 2'b01);
    tick();
    applyStimulus(2'b00, 14'h3FFF, 32'hDEADBEEF, 32'h12345678, 14'h3FFF, 1, 1);
    checkOutput("alu_exec_ctrl", alu_control, 14'h0001);
    checkOutput("alu_exec_src", {alu_src1, alu_src2}, {32'd5, 32'd7});
    checkOutput("alu_exec_no_rsp", rsp_valid, 0);
    tick();
    checkOutput("alu_rsp_valid", rsp_valid, 1);
    checkOutput("alu_rsp_id", rsp_id, 0);
    checkOutput("alu_rsp_data", {rsp_hi, rsp_lo}, {32'd0, 32'd12});
    checkOutput("alu_rsp_no_ready", req_ready, 0);
    tick();
    checkOutput("alu_back_idle", rsp_valid, 0);
    checkOutput("idle_alu_control", alu_control, 0);

    // A stray mult_end in IDLE must be ignored
    stray_end = 1'b1;
    #1;
    tick();
    stray_end = 1'b0;
    #1;
    checkOutput("stray_end_rsp", rsp_valid, 0);
    checkOutput("stray_end_begin", mult_begin, 0);

    // Multiply from requester 1: 0xFFFFFFFF * 2
    applyStimulus(2'b10, 0, 0, 0, 14'h0004, 32'hFFFFFFFF, 32'd2);
    checkOutput("mul_grant", req_ready, 2'b10);
    tick();
    applyStimulus(2'b00, 0, 0, 0, 14'h0001, 7, 7);
    for (int i = 0; i < MUL_LAT; i++) begin
      checkOutput("mul_begin_wait", mult_begin, 1);
      if (i == 0) checkOutput("mul_ops", {mult_op1, mult_op2}, {32'hFFFFFFFF, 32'd2});
      tick();
    end
    checkOutput("mul_rsp_valid", rsp_valid, 1);
    checkOutput("mul_begin_drop", mult_begin, 0);
    checkOutput("mul_rsp_data", {rsp_hi, rsp_lo}, 64'h00000001_FFFFFFFE);
    checkOutput("mul_rsp_id_err", {rsp_id, rsp_err}, 2'b10);
    tick();

    // Back-pressure: rsp_ready low for 10 cycles, then one handshake
    rsp_ready = 1'b0;
    applyStimulus(2'b01, 14'h0002, 100, 1, 0, 0, 0);
    checkOutput("stall_grant", req_ready, 2'b01);
    tick();
    applyStimulus(2'b11, 14'h0001, 9, 9, 14'h0001, 8, 8);
    tick();
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_rsp_valid", rsp_valid, 1);
      checkOutput("stall_rsp_data", {rsp_id, rsp_hi, rsp_lo}, {1'b0, 32'd0, 32'd99});
      checkOutput("stall_req_ready", req_ready, 0);
      tick();
    end
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
    rsp_ready = 1'b1;
    #1;
    checkOutput("stall_release_valid", rsp_valid, 1);
    tick();
    checkOutput("stall_single_hs", rsp_valid, 0);
    tick();
    checkOutput("stall_stays_idle", rsp_valid, 0);

    // Round-robin after reset with both requesters valid: 0,1,0,1
    resetn = 1'b0;
    #1;
    tick();
    resetn = 1'b1;
    #1;
    applyStimulus(2'b11, 14'h0001, 3, 4, 14'h0001, 10, 20);
    for (int k = 0; k < 4; k++) begin
      checkOutput("rr_grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      tick();
      tick();
      checkOutput("rr_rsp_id", rsp_id, k % 2);
      checkOutput("rr_rsp_lo", rsp_lo, (k % 2 == 1) ? 30 : 7);
      tick();
    end
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a multiply
    applyStimulus(2'b10, 0, 0, 0, 14'h0004, 3, 5);
    tick();
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("mid_mul_begin", mult_begin, 1);
    resetn = 1'b0;
    #1;
    checkOutput("mid_rst_begin", mult_begin, 0);
    checkOutput("mid_rst_valid", rsp_valid, 0);
    checkOutput("mid_rst_alu", {alu_control, alu_src1}, 0);
    tick();
    resetn = 1'b1;
    #1;
    saw_valid = 1'b0;
    saw_begin = 1'b0;
    for (int i = 0; i < 40; i++) begin
      saw_valid = saw_valid | rsp_valid;
      saw_begin = saw_begin | mult_begin;
      tick();
    end
    checkOutput("mid_rst_no_rsp", saw_valid, 0);
    checkOutput("mid_rst_no_begin", saw_begin, 0);
    applyStimulus(2'b11, 14'h0001, 1, 2, 14'h0001, 50, 50);
    checkOutput("post_rst_grant", req_ready, 2'b01);
    tick();
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("post_rst_rsp", {rsp_valid, rsp_id, rsp_lo}, {1'b1, 1'b0, 32'd3});
    tick();

`ifdef MUL_TIMEOUT_EN
    // Multiplier never finishes: the block times out after 8 MUL_WAIT cycles
    mul_on = 1'b0;
    applyStimulus(2'b10, 0, 0, 0, 14'h0004, 9, 9);
    checkOutput("to_grant", req_ready, 2'b10);
    tick();
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("to_wait_begin", mult_begin, 1);
      tick();
    end
    checkOutput("to_rsp_valid", rsp_valid, 1);
    checkOutput("to_begin_drop", mult_begin, 0);
    checkOutput("to_rsp_err", rsp_err, 1);
    checkOutput("to_rsp_data", {rsp_hi, rsp_lo}, 0);
    tick();
    mul_on = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_mul_scheduler.md
ALU_MUL_SCHEDULER -- requirements
Module: alu_mul_scheduler

Interface
REQ-001 The block SHALL have parameter MULT_TIMEOUT, default 64, giving the max cycles to wait for mult_end (used only with MUL_TIMEOUT_EN).
REQ-002 The block SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-003 The block SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid  input  2  bit i = requester i has an operation pending.
REQ-005 The block SHALL have port req_ready  output  2  bit i = requester i accepted this cycle.
REQ-006 The block SHALL have port req_ctrl  input  28  [13:0] requester 0, [27:14] requester 1; 14-bit ALU control word, bit 2 = multiply.
REQ-007 The block SHALL have ports req_src1 and req_src2  input  64 each  [31:0] requester 0, [63:32] requester 1.
REQ-008 The block SHALL have ports alu_control (output, 14), alu_src1 (output, 32), alu_src2 (output, 32) and alu_result (input, 32), connecting to the combinational ALU.
REQ-009 The block SHALL have ports mult_begin (output, 1), mult_op1 (output, 32), mult_op2 (output, 32), product (input, 64) and mult_end (input, 1), connecting to the multi-cycle multiplier.
REQ-010 The block SHALL have ports rsp_valid (output, 1), rsp_id (output, 1), rsp_err (output, 1), rsp_hi (output, 32) and rsp_lo (output, 32), which form the response, and input rsp_ready (1).

Function
REQ-011 The block SHALL implement states IDLE, ALU_EXEC, MUL_WAIT and RESP.
REQ-012 In IDLE, req_ready SHALL be combinational and one-hot or zero; it SHALL assert only for the granted requester with req_valid high.
REQ-013 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, that one wins.
REQ-014 On acceptance, the block SHALL latch ctrl, src1, src2 and id; later changes on req_* SHALL NOT affect the operation.
REQ-015 alu_control, alu_src1, alu_src2, mult_op1 and mult_op2 SHALL be driven from the latched values.
REQ-016 An accepted request with ctrl bit 2 = 0 SHALL go to ALU_EXEC for exactly 1 cycle, capture rsp_lo = alu_result and rsp_hi = 0, then go to RESP.
REQ-017 ALU latency SHALL be: accept in cycle N, rsp_valid high in cycle N+2.
REQ-018 An accepted request with ctrl bit 2 = 1 SHALL go to MUL_WAIT.
REQ-019 In MUL_WAIT, mult_begin SHALL be high continuously from the cycle after accept until the cycle mult_end is sampled high.
REQ-020 When mult_end is sampled high, the block SHALL capture rsp_hi = product[63:32] and rsp_lo = product[31:0], drop mult_begin and go to RESP.
REQ-021 In RESP, rsp_valid SHALL be high and rsp_hi, rsp_lo, rsp_id and rsp_err SHALL be stable until rsp_valid and rsp_ready are both high.
REQ-022 On that handshake, the block SHALL return to IDLE, and req_ready SHALL NOT assert in the same cycle as the handshake.
REQ-023 rsp_ready held low SHALL stall the block indefinitely in RESP with no new acceptance.
REQ-024 alu_control SHALL be 0 in IDLE; mult_begin SHALL be 0 outside MUL_WAIT.
REQ-025 Only one operation SHALL be in flight at a time.
REQ-026 mult_end asserting outside MUL_WAIT SHALL be ignored.

Reset
REQ-027 While resetn is low, the block SHALL immediately force: state IDLE, req_ready 0, rsp_valid 0, rsp_id 0, rsp_err 0, rsp_hi 0, rsp_lo 0, mult_begin 0, alu_control 0, latched operands 0.
REQ-028 Reset SHALL set the round-robin pointer so that requester 0 wins the first tie.
REQ-029 Reset mid-multiply SHALL abandon the operation with no response.

Configuration
REQ-030 With macro MUL_TIMEOUT_EN defined, a counter SHALL start on entry to MUL_WAIT.
REQ-031 With MUL_TIMEOUT_EN defined, if mult_end has not been seen after MULT_TIMEOUT cycles in MUL_WAIT, the block SHALL drop mult_begin and go to RESP with rsp_err = 1 and rsp_hi = rsp_lo = 0.
REQ-032 With MUL_TIMEOUT_EN undefined, MUL_WAIT SHALL wait indefinitely, rsp_err SHALL be tied 0, and no counter logic SHALL exist.

Verification
REQ-033 Requester 0 sends ctrl = 0x0001, src1 = 5, src2 = 7; the ALU model returns 12 -> rsp_valid high 2 cycles after accept with rsp_id = 0, rsp_lo = 12, rsp_hi = 0.
REQ-034 Requester 1 sends ctrl = 0x0004, src1 = 0xFFFFFFFF, src2 = 2; the multiplier model asserts mult_end after 33 cycles -> mult_begin high for the whole wait, then rsp_hi = 0x00000001, rsp_lo = 0xFFFFFFFE, rsp_id = 1.
REQ-035 Both requesters hold req_valid high for 4 operations -> grants after reset SHALL be 0,1,0,1.
REQ-036 rsp_ready held low for 10 cycles in RESP -> outputs stable, req_ready stays 0, single handshake on release.
REQ-037 resetn pulsed low mid-multiply -> mult_begin and rsp_valid drop immediately, no response follows, the next request is served normally.
REQ-038 With MUL_TIMEOUT_EN defined and MULT_TIMEOUT = 8, mult_end is never asserted -> RESP entered after 8 MUL_WAIT cycles with rsp_err = 1 and zero data.
